// File: rtl/hamming_enc_seq.sv
// ---------------------------------------------------------------------------
// hamming_enc_seq
//
// Sequential extended-Hamming (16,11) encoder working out of a byte-wide
// data memory. On an accepted start it walks NUM_MSG two-byte messages
// starting at SRC_BASE. For each message it reads the low byte, then the
// high byte, builds the 11-bit data word {hi[2:0], lo}, and writes the
// 16-bit SECDED code word to DST_BASE, high byte first. Each message takes
// exactly five cycles.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low reset
//   start      run request, sampled on the rising edge
//   busy       high while a run is in progress
//   done       high once a run has completed, held until the next start
//   mem_addr   data-memory byte address (8-bit, wraps modulo 256)
//   mem_we     data-memory write enable
//   mem_wdata  data-memory write data
//   mem_rdata  data-memory read data, valid one cycle after mem_addr
//   fsm_state  current FSM state, for observation only
//
// Start protocol: start is a level sampled on each rising edge. It is
// accepted only in IDLE or DONE; while a run is in progress it is ignored,
// so holding or re-pulsing it mid-run has no effect.
//
// Every output is decoded from registered state (state, index, captured
// bytes, done flag); there is no combinational path from start or
// mem_rdata to any output.
// ---------------------------------------------------------------------------
module hamming_enc_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [2:0] fsm_state
);

    localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
    localparam logic [7:0] DST_B    = 8'(DST_BASE);
    localparam logic [5:0] LAST_IDX = 6'(NUM_MSG - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        CAP   = 3'd3,
        WR_HI = 3'd4,
        WR_LO = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [5:0] idx;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       done_q;

    // Byte offset of the current message (2*i); address sums wrap at 8 bits.
    logic [7:0] offs;
    assign offs = {1'b0, idx, 1'b0};

    // -----------------------------------------------------------------------
    // Encoder datapath, driven only by the captured bytes.
    // -----------------------------------------------------------------------
    logic [11:1] d;
    logic        p8;
    logic        p4;
    logic        p2;
    logic        p1;
    logic        p0;
    logic [15:0] enc;

    assign d   = {hi[2:0], lo};
    assign p8  = ^d[11:5];
    assign p4  = (^d[11:8]) ^ (^d[4:2]);
    assign p2  = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    assign p1  = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    // Overall parity across data and Hamming bits gives double-error detection.
    assign p0  = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    assign enc = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

    // -----------------------------------------------------------------------
    // State register and datapath registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= 6'd0;
            lo     <= 8'd0;
            hi     <= 8'd0;
            done_q <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx    <= 6'd0;
                        done_q <= 1'b0;
                    end else if (state == DONE) begin
                        // done is set from the DONE state itself, so it
                        // becomes visible one edge after DONE is entered.
                        done_q <= 1'b1;
                    end
                end
                // Read data lags the address by one cycle: the low byte
                // addressed in RD_LO arrives during RD_HI, the high byte
                // addressed in RD_HI arrives during CAP.
                RD_HI: lo <= mem_rdata;
                CAP:   hi <= mem_rdata;
                WR_LO: begin
                    if (idx != LAST_IDX) begin
                        idx <= idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode.
    // -----------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RD_LO;
                end
            end
            RD_LO: begin
                busy     = 1'b1;
                mem_addr = SRC_B + offs;
                state_n  = RD_HI;
            end
            RD_HI: begin
                busy     = 1'b1;
                mem_addr = SRC_B + offs + 8'd1;
                state_n  = CAP;
            end
            CAP: begin
                busy    = 1'b1;
                state_n = WR_HI;
            end
            WR_HI: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_B + offs + 8'd1;
                mem_wdata = enc[15:8];
                state_n   = WR_LO;
            end
            WR_LO: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_B + offs;
                mem_wdata = enc[7:0];
                state_n   = (idx == LAST_IDX) ? DONE : RD_LO;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign done      = done_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_hamming_enc_seq.sv
// ---------------------------------------------------------------------------
// tb_hamming_enc_seq
//
// Two encoder instances share one clock and reset:
//   dut1: default parameters (15 messages, source 0, destination 30)
//   dut2: one message, destination 255 (address wrap case)
// Each instance has a small synchronous-read memory model. Expected code
// words come from a position-based Hamming reference (data bits placed at
// non-power-of-two positions, parity bit k covers positions with bit k set).
// ---------------------------------------------------------------------------
module tb_hamming_enc_seq;

    localparam int N1 = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic start2;

    // ---------------- DUT 1 ----------------
    logic       busy1, done1, we1;
    logic [7:0] addr1, wdata1, rdata1;
    logic [2:0] st1;

    hamming_enc_seq dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy1),
        .done      (done1),
        .mem_addr  (addr1),
        .mem_we    (we1),
        .mem_wdata (wdata1),
        .mem_rdata (rdata1),
        .fsm_state (st1)
    );

    // ---------------- DUT 2 ----------------
    logic       busy2, done2, we2;
    logic [7:0] addr2, wdata2, rdata2;
    logic [2:0] st2;

    hamming_enc_seq #(
        .NUM_MSG  (1),
        .SRC_BASE (0),
        .DST_BASE (255)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .busy      (busy2),
        .done      (done2),
        .mem_addr  (addr2),
        .mem_we    (we2),
        .mem_wdata (wdata2),
        .mem_rdata (rdata2),
        .fsm_state (st2)
    );

    // ---------------- memory models ----------------
    logic [7:0]  src1 [256];
    logic [7:0]  dst1 [256];
    logic [15:0] log1 [64];
    int          log1_n = 0;
    logic        clr1 = 1'b0;

    always @(posedge clk) begin
        rdata1 <= src1[addr1];
        if (clr1) begin
            log1_n <= 0;
            for (int k = 0; k < 256; k++) dst1[k] <= 8'hAA;
        end else if (we1) begin
            dst1[addr1] <= wdata1;
            if (log1_n < 64) log1[log1_n] <= {addr1, wdata1};
            log1_n <= log1_n + 1;
        end
    end

    logic [7:0]  src2 [256];
    logic [15:0] log2 [8];
    int          log2_n = 0;

    always @(posedge clk) begin
        rdata2 <= src2[addr2];
        if (we2) begin
            if (log2_n < 8) log2[log2_n] <= {addr2, wdata2};
            log2_n <= log2_n + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] msg [N1];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] enc;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: Hamming positions 1..15 plus overall parity at 0.
    function automatic logic [15:0] ref_enc(input logic [15:0] m);
        logic [10:0] data;
        logic [15:0] code;
        logic        par;
        int          k;
        data = m[10:0];
        code = '0;
        k    = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                code[pos] = data[k];
                k++;
            end
        end
        for (int pb = 1; pb < 16; pb = pb * 2) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if ((pos & pb) != 0) par = par ^ code[pos];
            end
            code[pb] = par;
        end
        code[0] = ^code[15:1];
        return code;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_start(input int which, input logic v);
        if (which == 1) start = v;
        else start2 = v;
    endtask

    // Load msg[] into dut1's source area, queue the expected writes,
    // clear the destination image and write log. Ends on a negedge.
    task automatic load1();
        logic [15:0] e;
        for (int i = 0; i < N1; i++) begin
            src1[2*i]     = msg[i][7:0];
            src1[2*i + 1] = msg[i][15:8];
            e = ref_enc(msg[i]);
            exp_q.push_back({8'(30 + 2*i + 1), e[15:8]});
            exp_q.push_back({8'(30 + 2*i), e[7:0]});
        end
        @(negedge clk);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
    endtask

    // Called on a negedge. Counts rising edges after the sampling edge
    // until done is seen high; optionally re-pulses start mid-run.
    task automatic run(input int which, input int repulse_at,
                       output int edges, output logic busy_mid);
        edges    = 0;
        busy_mid = 1'b0;
        drive_start(which, 1'b1);
        @(posedge clk);
        #1;
        drive_start(which, 1'b0);
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 10) busy_mid = (which == 1) ? busy1 : busy2;
            drive_start(which, edges == repulse_at);
            if ((which == 1) ? done1 : done2) break;
        end
        drive_start(which, 1'b0);
    endtask

    // Compare the first n logged writes of dut1 against the expected queue.
    task automatic check_log1(input int n, input string tag);
        logic [15:0] e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_exp_underflow"}, 32'(k), 32'(n));
                break;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_write%0d", tag, k), log1[k], e);
        end
    endtask

    task automatic check_idle_outputs1(input string tag, input logic [2:0] exp_st, input logic exp_done);
        chk({tag, "_state"}, st1, exp_st);
        chk({tag, "_busy"}, busy1, 1'b0);
        chk({tag, "_done"}, done1, exp_done);
        chk({tag, "_we"}, we1, 1'b0);
        chk({tag, "_addr"}, addr1, 8'd0);
        chk({tag, "_wdata"}, wdata1, 8'd0);
    endtask

    // ---------------- test sequence ----------------
    int          edges;
    logic        busy_mid;
    logic [15:0] e2;
    int          found;

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;

        tbl[0] = '{hi: 8'h07, lo: 8'hFF, enc: 16'hFFFF};
        tbl[1] = '{hi: 8'h00, lo: 8'h01, enc: 16'h000F};
        tbl[2] = '{hi: 8'hF8, lo: 8'h00, enc: 16'h0000};
        tbl[3] = '{hi: 8'h00, lo: 8'h02, enc: 16'h0033};
        tbl[4] = '{hi: 8'h04, lo: 8'h00, enc: 16'h8117};
        tbl[5] = '{hi: 8'hFF, lo: 8'hFF, enc: 16'hFFFF};

        // Reset state, with start held high to show reset dominates.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs1("reset", 3'd0, 1'b0);
        chk("reset_dut2_we", we2, 1'b0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // --- All-zero messages ---
        for (int i = 0; i < N1; i++) msg[i] = 16'h0000;
        load1();
        run(1, -1, edges, busy_mid);
        chk("zero_done_edge", edges, 76);
        chk("zero_busy_mid", busy_mid, 1'b1);
        chk("zero_write_count", log1_n, 30);
        check_log1(30, "zero");
        check_idle_outputs1("zero_after", 3'd6, 1'b1);
        repeat (3) @(negedge clk);
        chk("zero_done_hold", done1, 1'b1);

        // --- Table vectors plus random messages, start re-pulsed mid-run ---
        for (int i = 0; i < N1; i++) begin
            if (i < 6) msg[i] = {tbl[i].hi, tbl[i].lo};
            else       msg[i] = 16'($urandom);
        end
        load1();
        run(1, 20, edges, busy_mid);
        chk("tbl_done_edge", edges, 76);
        chk("tbl_busy_mid", busy_mid, 1'b1);
        chk("tbl_write_count", log1_n, 30);
        chk("tbl_first_write", log1[0], {8'd31, 8'hFF});
        chk("tbl_second_write", log1[1], {8'd30, 8'hFF});
        check_log1(30, "tbl");
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("tbl_vec%0d", t), {dst1[30 + 2*t + 1], dst1[30 + 2*t]}, tbl[t].enc);
        end

        // --- Reset during message 7 WR_HI ---
        for (int i = 0; i < N1; i++) msg[i] = 16'($urandom);
        load1();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (st1 == 3'd4 && addr1 == 8'd45) begin
                found = 1;
                break;
            end
        end
        chk("abort_reached_wr_hi", found, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_we", we1, 1'b0);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_done", done1, 1'b0);
        chk("abort_addr", addr1, 8'd0);
        chk("abort_state", st1, 3'd0);
        repeat (2) @(negedge clk);
        chk("abort_write_count", log1_n, 14);
        check_log1(14, "abort");
        chk("abort_exp_left", exp_q.size(), 16);
        exp_q.delete();
        chk("abort_no_hi_write", dst1[45], 8'hAA);
        chk("abort_no_lo_write", dst1[44], 8'hAA);

        // Restart straight out of reset release; the first edge must accept it.
        for (int i = 0; i < N1; i++) msg[i] = 16'($urandom);
        load1();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run(1, -1, edges, busy_mid);
        chk("restart_done_edge", edges, 76);
        chk("restart_write_count", log1_n, 30);
        check_log1(30, "restart");

        // --- Single message to destination 255: wrap to address 0 ---
        msg[0]  = 16'($urandom);
        src2[0] = msg[0][7:0];
        src2[1] = msg[0][15:8];
        e2      = ref_enc(msg[0]);
        run(2, -1, edges, busy_mid);
        chk("wrap_done_edge", edges, 6);
        chk("wrap_write_count", log2_n, 2);
        chk("wrap_hi_write", log2[0], {8'd0, e2[15:8]});
        chk("wrap_lo_write", log2[1], {8'd255, e2[7:0]});
        chk("wrap_state_done", st2, 3'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
